// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: fetch and load/store paths, timeout error ack.
// Optional MEM_ARB_RR_EN: round-robin grant when both ports request together.
module mem_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rdy,
    output logic              busy
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic              own_d;
    logic              we_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;
    logic [CW-1:0]     wait_cnt;
    logic              grant_d;
    logic              grant_i;
    logic              timeout;

`ifdef MEM_ARB_RR_EN
    logic last_d;

    // On contention, serve the port that did not win the previous grant.
    assign grant_d = d_req & (~if_req | ~last_d);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_d <= 1'b0;
        end else if (state == IDLE && (d_req || if_req)) begin
            last_d <= grant_d;
        end
    end
`else
    assign grant_d = d_req;
`endif

    assign grant_i = if_req & ~grant_d;
    assign timeout = (wait_cnt == CW'(MAX_WAIT - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (d_req || if_req) begin
                    state_nx = ACCESS;
                end
            end
            ACCESS: begin
                if (mem_rdy || timeout) begin
                    state_nx = RESP;
                end
            end
            RESP: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            own_d    <= 1'b0;
            we_r     <= 1'b0;
            addr_r   <= '0;
            wdata_r  <= '0;
            wait_cnt <= '0;
            err      <= 1'b0;
            if_rdata <= '0;
            d_rdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        own_d    <= 1'b1;
                        we_r     <= d_we;
                        addr_r   <= d_addr;
                        wdata_r  <= d_wdata;
                        wait_cnt <= '0;
                    end else if (grant_i) begin
                        own_d    <= 1'b0;
                        we_r     <= 1'b0;
                        addr_r   <= if_addr;
                        wait_cnt <= '0;
                    end
                end
                ACCESS: begin
                    // A ready in the last allowed cycle still completes normally.
                    if (mem_rdy) begin
                        err <= 1'b0;
                        if (!we_r) begin
                            if (own_d) begin
                                d_rdata <= mem_rdata;
                            end else begin
                                if_rdata <= mem_rdata;
                            end
                        end
                    end else if (timeout) begin
                        err <= 1'b1;
                        if (own_d) begin
                            d_rdata <= '0;
                        end else begin
                            if_rdata <= '0;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign mem_en    = (state == ACCESS);
    assign mem_we    = mem_en & we_r;
    assign mem_addr  = addr_r;
    assign mem_wdata = wdata_r;
    assign if_ack    = (state == RESP) & ~own_d;
    assign d_ack     = (state == RESP) & own_d;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: random transactions, queue scoreboard, memory model.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = 15;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_ack;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_ack;
    logic          err;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_rdy;
    logic          busy;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .MAX_WAIT(MW)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_rdata (if_rdata),
        .if_ack   (if_ack),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_rdata  (d_rdata),
        .d_ack    (d_ack),
        .err      (err),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_rdy  (mem_rdy),
        .busy     (busy)
    );

    typedef struct {
        bit          port_d;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        bit          err;
        int          wt;
        int          n_acc;
    } exp_t;

    exp_t        exp_q[$];
    int          tests = 0;
    int          fails = 0;
    logic [31:0] mem[logic [31:0]];
    logic [31:0] ref_mem[logic [31:0]];
    logic [31:0] ref_if_rdata = '0;
    logic [31:0] ref_d_rdata = '0;
    bit          ref_last_d = 1'b0;

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: one access with wt wait cycles before memory answers.
    task automatic model(input bit pd, input bit we, input logic [31:0] a,
                         input logic [31:0] wd, input int wt, output exp_t e);
        e.port_d = pd;
        e.we     = we;
        e.addr   = a;
        e.wdata  = wd;
        e.wt     = wt;
        e.err    = (wt + 1 > MW);
        e.n_acc  = e.err ? MW : wt + 1;
        if (e.err) begin
            e.rdata = '0;
        end else if (we) begin
            ref_mem[a] = wd;
            e.rdata    = ref_d_rdata;
        end else begin
            e.rdata = ref_mem.exists(a) ? ref_mem[a] : dflt(a);
        end
        if (pd) ref_d_rdata = e.rdata;
        else ref_if_rdata = e.rdata;
        ref_last_d = pd;
    endtask

    task automatic run_txn(input bit ui, input bit ud,
                           input logic [31:0] ia, input logic [31:0] da,
                           input bit dwe, input logic [31:0] dwd,
                           input int wi, input int wdw);
        exp_t e_i;
        exp_t e_d;
        bit   first_d;
        bit   pend_i;
        bit   pend_d;
        int   cyc;
`ifdef MEM_ARB_RR_EN
        first_d = ud && (!ui || !ref_last_d);
`else
        first_d = ud;
`endif
        if (first_d) begin
            model(1'b1, dwe, da, dwd, wdw, e_d);
            exp_q.push_back(e_d);
            if (ui) begin
                model(1'b0, 1'b0, ia, '0, wi, e_i);
                exp_q.push_back(e_i);
            end
        end else begin
            if (ui) begin
                model(1'b0, 1'b0, ia, '0, wi, e_i);
                exp_q.push_back(e_i);
            end
            if (ud) begin
                model(1'b1, dwe, da, dwd, wdw, e_d);
                exp_q.push_back(e_d);
            end
        end
        @(posedge clk);
        #1;
        if_addr = ia;
        d_addr  = da;
        d_we    = dwe;
        d_wdata = dwd;
        if_req  = ui;
        d_req   = ud;
        pend_i  = ui;
        pend_d  = ud;
        cyc     = 0;
        while ((pend_i || pend_d) && cyc < 200) begin
            @(negedge clk);
            if (if_ack && pend_i) begin
                pend_i = 1'b0;
                if_req = 1'b0;
                if (!ud) check("if_latency", cyc, 1 + e_i.n_acc);
            end
            if (d_ack && pend_d) begin
                pend_d = 1'b0;
                d_req  = 1'b0;
                if (!ui) check("d_latency", cyc, 1 + e_d.n_acc);
            end
            cyc++;
        end
        if (pend_i || pend_d) begin
            tests++;
            fails++;
            $display("FAIL txn_done: pending i=%0d d=%0d after %0d cycles",
                     pend_i, pend_d, cyc);
            if_req = 1'b0;
            d_req  = 1'b0;
            exp_q.delete();
        end
    endtask

    // Memory model and response monitor.
    initial begin
        int   acc;
        bit   rdy;
        exp_t e;
        acc       = 0;
        mem_rdy   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                acc     = 0;
                mem_rdy = 1'b0;
            end else begin
                if (mem_en) begin
                    acc++;
                    rdy = 1'b0;
                    if (exp_q.size() > 0) begin
                        check("cmd_we", mem_we, exp_q[0].we);
                        check("cmd_addr", mem_addr, exp_q[0].addr);
                        if (exp_q[0].we) check("cmd_wdata", mem_wdata, exp_q[0].wdata);
                        rdy = (acc == exp_q[0].wt + 1);
                    end
                    mem_rdy   = rdy;
                    mem_rdata = $urandom;
                    if (rdy) begin
                        if (mem_we) mem[mem_addr] = mem_wdata;
                        else if (mem.exists(mem_addr)) mem_rdata = mem[mem_addr];
                        else mem_rdata = dflt(mem_addr);
                    end
                end else begin
                    mem_rdy = 1'b0;
                end
                if (if_ack || d_ack) begin
                    if (if_ack && d_ack) begin
                        tests++;
                        fails++;
                        $display("FAIL dual_ack: both acks high");
                    end
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL stale_ack: if_ack=%0d d_ack=%0d none expected",
                                 if_ack, d_ack);
                    end else begin
                        e = exp_q.pop_front();
                        check("ack_port", d_ack, e.port_d);
                        check("err", err, e.err);
                        check("rdata", e.port_d ? d_rdata : if_rdata, e.rdata);
                        check("n_access", acc, e.n_acc);
                    end
                    acc = 0;
                end
            end
        end
    end

    initial begin
        int          cyc;
        int          r;
        int          wt[2];
        logic [31:0] a[2];
        exp_t        e;
        reset_n = 1'b0;
        if_req  = 1'b0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        if_addr = '0;
        d_addr  = '0;
        d_wdata = '0;
        mem[32'h40]     = 32'h2002_000A;
        ref_mem[32'h40] = 32'h2002_000A;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ctrl", {if_ack, d_ack, err, mem_en, mem_we, busy}, 0);
        check("rst_addr", {mem_addr, mem_wdata}, 0);
        check("rst_rdata", {if_rdata, d_rdata}, 0);
        @(negedge clk);
        reset_n = 1'b1;

        run_txn(1, 0, 32'h40, 0, 0, 0, 0, 0);
        run_txn(0, 1, 0, 32'h100, 1, 32'hDEAD_BEEF, 0, 3);
        run_txn(1, 1, 32'h100, 32'h40, 0, 0, 1, 0);
        run_txn(1, 1, 32'h44, 32'h100, 0, 0, 0, 2);
        run_txn(0, 1, 0, 32'h200, 0, 0, 0, MW);
        run_txn(0, 1, 0, 32'h100, 0, 0, 0, 0);
        run_txn(0, 1, 0, 32'h40, 0, 0, 0, MW - 1);
        run_txn(1, 0, 32'h48, 0, 0, 0, MW + 2, 0);
        run_txn(0, 1, 0, 32'h300, 1, 32'h1234_5678, 0, MW + 2);

        // Abandon a fetch in its second ACCESS cycle.
        @(posedge clk);
        #1;
        if_addr = 32'h80;
        if_req  = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_ctrl", {if_ack, d_ack, err, mem_en, mem_we, busy}, 0);
        check("midrst_data", {mem_addr, mem_wdata, if_rdata, d_rdata}, 0);
        repeat (2) @(posedge clk);
        ref_if_rdata = '0;
        ref_d_rdata  = '0;
        ref_last_d   = 1'b0;
        model(1'b0, 1'b0, 32'h80, '0, 0, e);
        exp_q.push_back(e);
        @(negedge clk);
        reset_n = 1'b1;
        cyc = 0;
        while (!if_ack && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        if_req = 1'b0;
        check("rst_regrant_lat", cyc, 2);

        for (int n = 0; n < 80; n++) begin
            for (int k = 0; k < 2; k++) begin
                a[k] = 32'h1000 + (32'($urandom_range(0, 15)) << 2);
                r    = $urandom_range(0, 9);
                if (r < 6) wt[k] = r;
                else if (r < 8) wt[k] = $urandom_range(3, MW - 2);
                else wt[k] = $urandom_range(MW - 1, MW + 3);
            end
            r = $urandom_range(0, 3);
            run_txn(r != 1, r != 0, a[0], a[1], 1'($urandom_range(0, 1)),
                    $urandom, wt[0], wt[1]);
        end

        repeat (3) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-port unified memory between the multicycle CPU's instruction-fetch path and its load/store path. It grants one requester at a time, drives the memory's command port, and waits for memory ready. It returns read data with a one-cycle acknowledge, or an error acknowledge if memory never responds. It sits between `control_unit`/datapath and the memory model, replacing direct `MemReadI`/`MemRead`/`MemWrite` wiring.

## Interface
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width.
- `MAX_WAIT`, 15, maximum ACCESS cycles before timeout (≥1; counter width `$clog2(MAX_WAIT+1)`).

- `clk`  in  1  system clock, rising edge.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `if_req`  in  1  instruction-fetch request (level; held until `if_ack`).
- `if_addr`  in  ADDR_W  fetch address.
- `if_rdata`  out  DATA_W  fetched word, valid with `if_ack`.
- `if_ack`  out  1  one-cycle completion pulse, fetch port.
- `d_req`  in  1  data request (level; held until `d_ack`).
- `d_we`  in  1  1 = store, 0 = load.
- `d_addr`  in  ADDR_W  data address.
- `d_wdata`  in  DATA_W  store data.
- `d_rdata`  out  DATA_W  load data, valid with `d_ack`.
- `d_ack`  out  1  one-cycle completion pulse, data port.
- `err`  out  1  timeout flag, valid with either ack.
- `mem_en`  out  1  memory command valid.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_rdata`  in  DATA_W  memory read data, valid when `mem_rdy`.
- `mem_rdy`  in  1  memory completion, sampled only while `mem_en`=1.
- `busy`  out  1  high in ACCESS and RESP.

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE: if `d_req`=1, grant data and latch `d_we`/`d_addr`/`d_wdata`. Else if `if_req`=1, grant fetch and latch `if_addr`, with `we`=0. On a grant, go to ACCESS and clear `wait_cnt`. With no request, stay in IDLE.
- Priority: data over fetch when both requests are asserted in the same IDLE cycle. This is fixed unless the round-robin option is compiled in.
- ACCESS: `mem_en`=1. `mem_we`, `mem_addr` and `mem_wdata` come from the latched registers and are stable for the whole state. Inputs `d_*`/`if_*` are ignored.
  - `mem_rdy`=1: latch `mem_rdata` into the owner's rdata register (store: register unchanged), clear `err`, go to RESP.
  - `mem_rdy`=0 with `wait_cnt`=MAX_WAIT−1: set `err`=1, load 0 into the owner's rdata register, go to RESP.
  - Otherwise increment `wait_cnt`.
  - `mem_rdy` takes precedence over timeout in the same cycle.
- RESP: pulse the owner's ack for exactly one cycle; the other ack stays 0. Requests are ignored. Go to IDLE.
- rdata and `err` hold their value until the next completion on that port (`err` is shared and updates on every completion).
- Requester rule: drop `req` on the cycle it samples its ack high. A req still high in the IDLE that follows is treated as a new access.

## Timing
- Reset (asynchronous, while `reset_n`=0): state IDLE. All outputs 0: `if_ack`, `d_ack`, `err`, `mem_en`, `mem_we`, `busy`, `mem_addr`, `mem_wdata`, `if_rdata`, `d_rdata`. `wait_cnt` 0; last-grant register = fetch.
- Reset mid-access: the access is abandoned and no ack is issued. Requests still held are re-arbitrated in the first IDLE cycle after `reset_n` rises.
- Zero-wait memory: req high in cycle 0 (IDLE) → `mem_en` in cycle 1 → ack in cycle 2 → IDLE in cycle 3. One access takes 3 cycles.
- N wait cycles (`mem_rdy` first high in the Nth ACCESS cycle, N ≤ MAX_WAIT): ack N+1 cycles after the grant edge.
- Timeout: exactly MAX_WAIT ACCESS cycles, then RESP with `err`=1.
- All outputs are registered or decoded from state only; no combinational path from inputs to outputs.

## Configuration
- `MEM_ARB_RR_EN` defined: when both requests are asserted in IDLE, grant the port opposite the last-grant register. The register updates at every grant; after reset, data wins first.
- `MEM_ARB_RR_EN` undefined: fixed data-over-fetch priority. The last-grant register is not built.

## Test plan
- Zero-wait fetch: `if_req`=1, `if_addr`=0x40, memory returns 0x2002000A with `mem_rdy` in the first ACCESS cycle → `mem_en` high 1 cycle, `if_ack` in cycle 2, `if_rdata`=0x2002000A, `err`=0.
- Store with 3 waits: `d_we`=1, `d_addr`=0x100, `d_wdata`=0xDEADBEEF, `mem_rdy` on the 4th ACCESS cycle → `mem_we`/`mem_addr`/`mem_wdata` stable for 4 cycles, `d_ack` 5 cycles after the grant edge, `d_rdata` unchanged.
- Simultaneous requests, macro off: `if_req` and `d_req` asserted together, held until acked → data served first, fetch granted in the IDLE after `d_ack`.
- Same stimulus with `MEM_ARB_RR_EN` defined, both requests held for 4 accesses → grants alternate D, I, D, I.
- Timeout: `d_req` load, `mem_rdy` tied 0 → ACCESS for exactly 15 cycles, then `d_ack`=1 with `err`=1, `d_rdata`=0. A subsequent zero-wait load clears `err`.
- Reset mid-access: pull `reset_n` low in the 2nd ACCESS cycle → all outputs 0 immediately. With `if_req` held, a fresh grant follows the first IDLE after release, and no stale ack appears.
